// File: rtl/vga_pkg.sv
// Shared VGA constants: 640x480@60 timing defaults, RRGGBB colour palette,
// and the blanking-signal bundle carried through the alignment pipeline.
package vga_pkg;

  localparam int CNT_W = 10;

  localparam int H_ACTIVE_DEF   = 640;
  localparam int H_FP_DEF       = 16;
  localparam int H_SYNC_DEF     = 96;
  localparam int H_BP_DEF       = 48;
  localparam int V_ACTIVE_DEF   = 480;
  localparam int V_FP_DEF       = 10;
  localparam int V_SYNC_DEF     = 2;
  localparam int V_BP_DEF       = 33;
  localparam int PIPE_DELAY_DEF = 1;

  typedef logic [5:0] color_t;

  localparam color_t COLOR_BLACK  = 6'b000000;
  localparam color_t COLOR_BLUE   = 6'b000011;
  localparam color_t COLOR_GREEN  = 6'b001100;
  localparam color_t COLOR_RED    = 6'b110000;
  localparam color_t COLOR_YELLOW = 6'b111100;
  localparam color_t COLOR_WHITE  = 6'b111111;

  // Sync pulses are active-low, so the idle (blanked) value has both syncs high.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic active;
  } blank_t;

  localparam blank_t BLANK_IDLE = '{hsync: 1'b1, vsync: 1'b1, active: 1'b0};

  function automatic logic in_range(input logic [CNT_W-1:0] v,
                                    input logic [CNT_W-1:0] lo,
                                    input logic [CNT_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Bundle between the timing generator (master) and the pixel renderer /
// display side (slave).
interface vga_timing_if;
  import vga_pkg::*;

  logic [CNT_W-1:0] x_px;
  logic [CNT_W-1:0] y_px;
  color_t           color_in;
  color_t           rgb;
  logic             hsync;
  logic             vsync;
  logic             active;
  logic             frame_start;

  modport master (
    output x_px, y_px, rgb, hsync, vsync, active, frame_start,
    input  color_in
  );

  modport slave (
    input  x_px, y_px, rgb, hsync, vsync, active, frame_start,
    output color_in
  );

endinterface

// File: rtl/sync_delay.sv
// Fixed-depth shift register with synchronous clear to a per-bit value.
// DEPTH=0 degenerates to a wire.
module sync_delay #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_clk_clr;
      assign unused_clk_clr = clk ^ clr;
      assign dout = din;
    end else begin : g_shift
      logic [WIDTH-1:0] stages [DEPTH];

      always_ff @(posedge clk) begin
        if (clr) begin
          for (int i = 0; i < DEPTH; i++) stages[i] <= CLR_VAL;
        end else begin
          stages[0] <= din;
          for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
        end
      end

      assign dout = stages[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing.sv
// VGA timing generator: free-running pixel/line counters, sync and blanking
// delayed to line up with the renderer's colour, then one output register.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int H_FP       = H_FP_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BP       = H_BP_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int V_FP       = V_FP_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BP       = V_BP_DEF,
  parameter int PIPE_DELAY = PIPE_DELAY_DEF
) (
  input  logic         clk,
  input  logic         clr,
  vga_timing_if.master bus
);

  localparam logic [CNT_W-1:0] H_MAX    = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_MAX    = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [CNT_W-1:0] hc;
  logic [CNT_W-1:0] vc;
  blank_t           raw;
  blank_t           dly;
  blank_t           out_q;
  color_t           rgb_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      hc <= '0;
      vc <= '0;
    end else if (hc == H_MAX) begin
      hc <= '0;
      vc <= (vc == V_MAX) ? '0 : vc + CNT_W'(1);
    end else begin
      hc <= hc + CNT_W'(1);
    end
  end

  always_comb begin
    raw        = BLANK_IDLE;
    raw.hsync  = !in_range(hc, HS_START, HS_END);
    raw.vsync  = !in_range(vc, VS_START, VS_END);
    raw.active = (hc < H_ACT) && (vc < V_ACT);
  end

  // Match the renderer's latency so blanking and sync describe the same pixel
  // as the colour arriving on color_in.
  sync_delay #(
    .WIDTH   ($bits(blank_t)),
    .DEPTH   (PIPE_DELAY),
    .CLR_VAL (BLANK_IDLE)
  ) u_sync_delay (
    .clk  (clk),
    .clr  (clr),
    .din  (raw),
    .dout (dly)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      rgb_q <= COLOR_BLACK;
      out_q <= BLANK_IDLE;
    end else begin
      rgb_q <= dly.active ? bus.color_in : COLOR_BLACK;
      out_q <= dly;
    end
  end

  assign bus.x_px   = hc;
  assign bus.y_px   = vc;
  assign bus.rgb    = rgb_q;
  assign bus.hsync  = out_q.hsync;
  assign bus.vsync  = out_q.vsync;
  assign bus.active = out_q.active;
  // Counters sit at 0,0 throughout reset; gating with clr keeps the pulse
  // to the single cycle after release.
  assign bus.frame_start = (hc == '0) && (vc == '0) && !clr;

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing: one full-size instance for line timing and
// three reduced-geometry instances (25x15 total) for frame, blanking and alignment.
module tb_vga_timing;
  import vga_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  vga_timing_if bus_def ();
  vga_timing_if bus_s0 ();
  vga_timing_if bus_s1 ();
  vga_timing_if bus_s2 ();

  vga_timing u_def (.clk(clk), .clr(clr), .bus(bus_def));

  vga_timing #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
               .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .PIPE_DELAY(0))
    u_s0 (.clk(clk), .clr(clr), .bus(bus_s0));

  vga_timing #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
               .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .PIPE_DELAY(1))
    u_s1 (.clk(clk), .clr(clr), .bus(bus_s1));

  vga_timing #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
               .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3), .PIPE_DELAY(2))
    u_s2 (.clk(clk), .clr(clr), .bus(bus_s2));

  // Renderers: constant colours, and x=15 marked red with 0 or 2 clocks latency.
  logic [9:0] x_d1, x_d2;
  always @(posedge clk) begin
    x_d1 <= bus_s2.x_px;
    x_d2 <= x_d1;
  end

  assign bus_def.color_in = COLOR_WHITE;
  assign bus_s1.color_in  = COLOR_YELLOW;
  assign bus_s0.color_in  = (bus_s0.x_px == 10'd15) ? COLOR_RED : COLOR_BLUE;
  assign bus_s2.color_in  = (x_d2 == 10'd15) ? COLOR_RED : COLOR_GREEN;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the first cycle after release (counters at 0,0).
  task automatic do_reset(input int cycles);
    clr = 1'b1;
    repeat (cycles) tick();
    clr = 1'b0;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clr = 1'b1;
    repeat (5) tick();
    n_cmp++; if (bus_def.x_px !== 10'd0) begin n_mis++; $display("FAIL reset_x: got %0d expected 0", bus_def.x_px); end
    n_cmp++; if (bus_def.y_px !== 10'd0) begin n_mis++; $display("FAIL reset_y: got %0d expected 0", bus_def.y_px); end
    n_cmp++; if (bus_def.hsync !== 1'b1) begin n_mis++; $display("FAIL reset_hsync: got %b expected 1", bus_def.hsync); end
    n_cmp++; if (bus_def.vsync !== 1'b1) begin n_mis++; $display("FAIL reset_vsync: got %b expected 1", bus_def.vsync); end
    n_cmp++; if (bus_def.active !== 1'b0) begin n_mis++; $display("FAIL reset_active: got %b expected 0", bus_def.active); end
    n_cmp++; if (bus_def.rgb !== COLOR_BLACK) begin n_mis++; $display("FAIL reset_rgb: got %b expected 000000", bus_def.rgb); end
    n_cmp++; if (bus_def.frame_start !== 1'b0) begin n_mis++; $display("FAIL reset_fs_held: got %b expected 0", bus_def.frame_start); end
    clr = 1'b0;
    #1;
    n_cmp++; if (bus_def.frame_start !== 1'b1) begin n_mis++; $display("FAIL reset_fs_release: got %b expected 1", bus_def.frame_start); end
    n_cmp++; if (bus_s2.frame_start !== 1'b1) begin n_mis++; $display("FAIL reset_fs_release_s2: got %b expected 1", bus_s2.frame_start); end
  endtask

  task automatic test_line_timing();
    int wrap_at, y_at_wrap, first_low, low_cnt, act_cnt, first_act, seq_err;
    wrap_at = -1; y_at_wrap = -1; first_low = -1; low_cnt = 0;
    act_cnt = 0; first_act = -1; seq_err = 0;
    do_reset(3);
    for (int n = 0; n < 810; n++) begin
      if (n < 800 && bus_def.x_px !== 10'(n)) seq_err++;
      if (n > 0 && wrap_at < 0 && bus_def.x_px === 10'd0) begin
        wrap_at = n;
        y_at_wrap = int'(bus_def.y_px);
      end
      if (n < 800) begin
        if (bus_def.hsync === 1'b0) begin
          low_cnt++;
          if (first_low < 0) first_low = n;
        end
        if (bus_def.active === 1'b1) begin
          act_cnt++;
          if (first_act < 0) first_act = n;
        end
      end
      tick();
    end
    n_cmp++; if (wrap_at != 800) begin n_mis++; $display("FAIL line_wrap: got %0d expected 800", wrap_at); end
    n_cmp++; if (y_at_wrap != 1) begin n_mis++; $display("FAIL line_vc_inc: got %0d expected 1", y_at_wrap); end
    n_cmp++; if (seq_err != 0) begin n_mis++; $display("FAIL line_x_seq: got %0d bad cycles expected 0", seq_err); end
    n_cmp++; if (low_cnt != 96) begin n_mis++; $display("FAIL hsync_width: got %0d expected 96", low_cnt); end
    n_cmp++; if (first_low != 658) begin n_mis++; $display("FAIL hsync_start: got %0d expected 658", first_low); end
    n_cmp++; if (act_cnt != 640) begin n_mis++; $display("FAIL line_active_cnt: got %0d expected 640", act_cnt); end
    n_cmp++; if (first_act != 2) begin n_mis++; $display("FAIL line_active_start: got %0d expected 2", first_act); end
  endtask

  // Frame period, vsync, blanking (s1) and colour alignment (s0, s2) in one pass.
  task automatic test_frame_blank_align();
    int fs_q[$];
    int vs_low, vs_first, act_cnt, yel_cnt, blank_err;
    int red0, red0_bad, blue0, red2, red2_bad, green2;
    vs_low = 0; vs_first = -1; act_cnt = 0; yel_cnt = 0; blank_err = 0;
    red0 = 0; red0_bad = 0; blue0 = 0; red2 = 0; red2_bad = 0; green2 = 0;
    do_reset(3);
    for (int n = 0; n < 760; n++) begin
      if (bus_s1.frame_start === 1'b1) fs_q.push_back(n);
      if (n < 375) begin
        if (bus_s1.vsync === 1'b0) begin
          vs_low++;
          if (vs_first < 0) vs_first = n;
        end
        if (bus_s1.active === 1'b1) act_cnt++;
        if (bus_s1.rgb === COLOR_YELLOW) yel_cnt++;
        if (bus_s1.rgb !== (bus_s1.active === 1'b1 ? COLOR_YELLOW : COLOR_BLACK)) blank_err++;
        if (bus_s0.rgb === COLOR_RED) begin
          red0++;
          if (n % 25 != 16 || n / 25 >= 8) red0_bad++;
        end
        if (bus_s0.rgb === COLOR_BLUE) blue0++;
        if (bus_s2.rgb === COLOR_RED) begin
          red2++;
          if (n % 25 != 18 || n / 25 >= 8) red2_bad++;
        end
        if (bus_s2.rgb === COLOR_GREEN) green2++;
      end
      tick();
    end
    n_cmp++; if (fs_q.size() != 3) begin n_mis++; $display("FAIL fs_count: got %0d expected 3", fs_q.size()); end
    if (fs_q.size() >= 3) begin
      n_cmp++; if (fs_q[0] != 0) begin n_mis++; $display("FAIL fs_first: got %0d expected 0", fs_q[0]); end
      n_cmp++; if (fs_q[1] - fs_q[0] != 375) begin n_mis++; $display("FAIL fs_period: got %0d expected 375", fs_q[1] - fs_q[0]); end
      n_cmp++; if (fs_q[2] - fs_q[1] != 375) begin n_mis++; $display("FAIL fs_period2: got %0d expected 375", fs_q[2] - fs_q[1]); end
    end
    n_cmp++; if (vs_low != 50) begin n_mis++; $display("FAIL vsync_width: got %0d expected 50", vs_low); end
    n_cmp++; if (vs_first != 252) begin n_mis++; $display("FAIL vsync_start: got %0d expected 252", vs_first); end
    n_cmp++; if (act_cnt != 128) begin n_mis++; $display("FAIL frame_active_cnt: got %0d expected 128", act_cnt); end
    n_cmp++; if (yel_cnt != 128) begin n_mis++; $display("FAIL blank_colour_cnt: got %0d expected 128", yel_cnt); end
    n_cmp++; if (blank_err != 0) begin n_mis++; $display("FAIL blank_rgb: got %0d bad cycles expected 0", blank_err); end
    n_cmp++; if (red0 != 8) begin n_mis++; $display("FAIL align_pd0_red_cnt: got %0d expected 8", red0); end
    n_cmp++; if (red0_bad != 0) begin n_mis++; $display("FAIL align_pd0_pos: got %0d misplaced expected 0", red0_bad); end
    n_cmp++; if (blue0 != 120) begin n_mis++; $display("FAIL align_pd0_blue_cnt: got %0d expected 120", blue0); end
    n_cmp++; if (red2 != 8) begin n_mis++; $display("FAIL align_pd2_red_cnt: got %0d expected 8", red2); end
    n_cmp++; if (red2_bad != 0) begin n_mis++; $display("FAIL align_pd2_pos: got %0d misplaced expected 0", red2_bad); end
    n_cmp++; if (green2 != 120) begin n_mis++; $display("FAIL align_pd2_green_cnt: got %0d expected 120", green2); end
  endtask

  task automatic test_mid_frame_reset();
    int found, hs_first, vs_low;
    found = 0; hs_first = -1; vs_low = 0;
    do_reset(3);
    for (int n = 0; n < 400 && found == 0; n++) begin
      if (bus_s1.x_px === 10'd19 && bus_s1.y_px === 10'd10) found = 1;
      else tick();
    end
    n_cmp++; if (found != 1) begin n_mis++; $display("FAIL mid_reach: got %0d expected 1 (hc=19 vc=10 never seen)", found); end
    n_cmp++; if (bus_s1.vsync !== 1'b0) begin n_mis++; $display("FAIL mid_vsync_pre: got %b expected 0", bus_s1.vsync); end
    clr = 1'b1;
    tick();
    n_cmp++; if (bus_s1.hsync !== 1'b1) begin n_mis++; $display("FAIL mid_hsync: got %b expected 1", bus_s1.hsync); end
    n_cmp++; if (bus_s1.vsync !== 1'b1) begin n_mis++; $display("FAIL mid_vsync: got %b expected 1", bus_s1.vsync); end
    n_cmp++; if (bus_s1.x_px !== 10'd0) begin n_mis++; $display("FAIL mid_x: got %0d expected 0", bus_s1.x_px); end
    n_cmp++; if (bus_s1.y_px !== 10'd0) begin n_mis++; $display("FAIL mid_y: got %0d expected 0", bus_s1.y_px); end
    n_cmp++; if (bus_s1.frame_start !== 1'b0) begin n_mis++; $display("FAIL mid_fs_held: got %b expected 0", bus_s1.frame_start); end
    clr = 1'b0;
    #1;
    n_cmp++; if (bus_s1.frame_start !== 1'b1) begin n_mis++; $display("FAIL mid_fs_release: got %b expected 1", bus_s1.frame_start); end
    for (int n = 0; n < 25; n++) begin
      if (bus_s1.hsync === 1'b0 && hs_first < 0) hs_first = n;
      if (bus_s1.vsync === 1'b0) vs_low++;
      tick();
    end
    n_cmp++; if (hs_first != 20) begin n_mis++; $display("FAIL mid_hsync_restart: got %0d expected 20", hs_first); end
    n_cmp++; if (vs_low != 0) begin n_mis++; $display("FAIL mid_vsync_partial: got %0d low cycles expected 0", vs_low); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_line_timing();
    test_frame_blank_align();
    test_mid_frame_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP/H_SYNC/H_BP, defaults 16/96/48, horizontal front porch/sync/back porch in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 SHALL have parameter V_FP/V_SYNC/V_BP, defaults 10/2/33, vertical front porch/sync/back porch in lines.
REQ-005 SHALL have parameter PIPE_DELAY, default 1, renderer latency in clocks (legal range 0..4).
REQ-006 SHALL have port clk  input  1  pixel clock (25 MHz); sole clock; all logic on rising edge.
REQ-007 SHALL have port clr  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port x_px  output  10  current horizontal counter, fed to pixel renderers.
REQ-009 SHALL have port y_px  output  10  current vertical counter, fed to pixel renderers.
REQ-010 SHALL have port color_in  input  6  RRGGBB pixel colour from renderer, valid PIPE_DELAY clocks after x_px/y_px.
REQ-011 SHALL have port rgb  output  6  colour to DAC, forced black outside the active area.
REQ-012 SHALL have port hsync, vsync  output  1 each  sync pulses, active-low.
REQ-013 SHALL have port active  output  1  high when rgb belongs to a visible pixel.
REQ-014 SHALL have port frame_start  output  1  one-clock pulse when x_px=0 and y_px=0.

Function
REQ-015 SHALL hold horizontal counter hc in 0..H_TOTAL-1 (H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP=800), incrementing every clock.
REQ-016 SHALL wrap hc from H_TOTAL-1 to 0 and in that same clock increment vc, holding vc otherwise.
REQ-017 SHALL wrap vc from V_TOTAL-1 (524) to 0 when hc wraps; frame = 420000 clocks.
REQ-018 SHALL drive x_px=hc and y_px=vc directly (registered counters, zero added latency).
REQ-019 SHALL compute raw hsync low for hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656,751].
REQ-020 SHALL compute raw vsync low for vc in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [490,491].
REQ-021 SHALL compute raw active = (hc<H_ACTIVE) and (vc<V_ACTIVE).
REQ-022 SHALL delay raw hsync, vsync, active by exactly PIPE_DELAY clocks before driving outputs, so they align with color_in.
REQ-023 SHALL register rgb as color_in when delayed active=1, else 6'b000000; rgb, hsync, vsync, active then share one extra register stage (total latency PIPE_DELAY+1 from counter).
REQ-024 SHALL assert frame_start for exactly the clock where hc=0 and vc=0, undelayed, aligned with x_px/y_px.
REQ-025 SHALL use only unsigned arithmetic; all comparisons on 10-bit values; no counter ever exceeds its TOTAL-1.

Reset
REQ-026 SHALL, on clr=1 at a clock edge, set hc=0, vc=0, all delay stages to blank (hsync=1, vsync=1, active=0), rgb=0.
REQ-027 SHALL hold all outputs at reset values while clr=1: x_px=0, y_px=0, hsync=1, vsync=1, active=0, rgb=0, frame_start=0.
REQ-028 SHALL, on the first clock after clr deasserts, present hc=0, vc=0 with frame_start=1; clr mid-frame restarts the frame cleanly with no partial sync pulse.

Structure
REQ-029 SHALL take timing defaults and colour constants (black, blue, green, red, yellow, white) from shared package vga_pkg.
REQ-030 SHALL implement the PIPE_DELAY alignment as one sub-module, sync_delay (parameterised width/depth shift register, synchronous clear, clear value per bit).
REQ-031 SHALL contain no combinational path from color_in to any output.

Verification
REQ-032 SHALL check reset: clr high 5 clocks -> x_px=0, y_px=0, hsync=1, vsync=1, active=0, rgb=0; first clock after release frame_start=1.
REQ-033 SHALL check line timing: count clocks from release -> hc wraps after 800 clocks; hsync output low exactly 96 clocks, first low when hc=656+PIPE_DELAY+1.
REQ-034 SHALL check frame timing: frame_start pulses every 420000 clocks; vsync low for 1600 clocks starting on line 490.
REQ-035 SHALL check blanking: color_in held 6'b111100 -> rgb=6'b111100 for 640x480 pixels per frame, rgb=0 elsewhere, active count=307200 per frame.
REQ-036 SHALL check alignment: color_in driven as function of delayed x_px (pixel x=639 marked red) -> rgb red exactly on last active pixel of each line, for PIPE_DELAY=0 and 2.
REQ-037 SHALL check mid-frame reset: clr pulsed 1 clock at hc=700, vc=491 -> next clock hsync=1, vsync=1, x_px=0, y_px=0, frame_start=1 after release.
